// File: rtl/m_lsu_pkg.sv
// Shared definitions for the M-stage load/store unit: DM opcodes, FSM states,
// exception codes and the alignment rule.
package m_lsu_pkg;

    localparam logic [2:0] DM_W  = 3'd0;
    localparam logic [2:0] DM_H  = 3'd1;
    localparam logic [2:0] DM_HU = 3'd2;
    localparam logic [2:0] DM_B  = 3'd3;
    localparam logic [2:0] DM_BU = 3'd4;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    // Unknown opcodes fall back to word rules so they can never slip past as bytes.
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] a);
        case (op)
            DM_H, DM_HU: is_aligned = ~a[0];
            DM_B, DM_BU: is_aligned = 1'b1;
            default:     is_aligned = (a == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/m_lsu_align.sv
// Combinational lane logic: byte enables and replicated write data for stores,
// lane extraction with sign/zero extension for loads.
module m_lsu_align
    import m_lsu_pkg::*;
(
    input  logic [2:0]  dm_op,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd
);

    logic [7:0]  lane_byte [4];
    logic [15:0] lane_half [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign lane_byte[gi] = rdata[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half
            assign lane_half[gi] = rdata[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = lane_byte[a];
    assign sel_half = lane_half[a[1]];

    // The unsigned variants only change load extension; stores treat hu/bu as h/b.
    always_comb begin
        be    = 4'b1111;
        wdata = wd;
        rd    = rdata;
        case (dm_op)
            DM_H, DM_HU: begin
                be    = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wd[15:0]}};
                rd    = (dm_op == DM_H) ? {{16{sel_half[15]}}, sel_half} : {16'h0000, sel_half};
            end
            DM_B, DM_BU: begin
                be    = 4'b0001 << a;
                wdata = {4{wd[7:0]}};
                rd    = (dm_op == DM_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'h00_0000, sel_byte};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: turns a pipeline access into one req/ack bus
// transaction, stalls until it completes, and reports address/bus errors.
module m_lsu
    import m_lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT     = 32'h0000_2FFF,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        valid_in,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [2:0]  dm_op,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic        stall,
    output logic        done,
    output logic [31:0] rd,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic [31:0] exc_pc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       op_reg, op_next;
    logic [1:0]       a_reg, a_next;

    logic        done_reg, done_next;
    logic [31:0] rd_reg, rd_next;
    logic        adel_reg, adel_next;
    logic        ades_reg, ades_next;
    logic        err_reg, err_next;
    logic [31:0] exc_pc_reg, exc_pc_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] baddr_reg, baddr_next;
    logic [3:0]  be_reg, be_next;
    logic [31:0] wdata_reg, wdata_next;

    logic        access;
    logic        legal;
    logic [2:0]  al_op;
    logic [1:0]  al_a;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rd;

    assign access = valid_in & (mem_rd | mem_wr);
    assign legal  = is_aligned(dm_op, addr[1:0]) && (addr <= ADDR_LIMIT);

    // One lane block serves both phases: store lanes from live inputs in IDLE,
    // load extraction from the latched opcode/offset while waiting for ack.
    assign al_op = (state_reg == ST_REQ) ? op_reg : dm_op;
    assign al_a  = (state_reg == ST_REQ) ? a_reg  : addr[1:0];

    m_lsu_align u_align (
        .dm_op (al_op),
        .a     (al_a),
        .wd    (wd),
        .rdata (bus_rdata),
        .be    (al_be),
        .wdata (al_wdata),
        .rd    (al_rd)
    );

    assign stall = ((state_reg == ST_IDLE) & access) | (state_reg == ST_REQ);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        a_next      = a_reg;
        done_next   = 1'b0;
        adel_next   = 1'b0;
        ades_next   = 1'b0;
        err_next    = 1'b0;
        rd_next     = rd_reg;
        exc_pc_next = exc_pc_reg;
        req_next    = req_reg;
        we_next     = we_reg;
        baddr_next  = baddr_reg;
        be_next     = be_reg;
        wdata_next  = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    exc_pc_next = pc;
                    if (legal) begin
                        state_next = ST_REQ;
                        cnt_next   = '0;
                        req_next   = 1'b1;
                        we_next    = mem_wr;
                        baddr_next = {addr[31:2], 2'b00};
                        be_next    = al_be;
                        wdata_next = al_wdata;
                        op_next    = dm_op;
                        a_next     = addr[1:0];
                    end else begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        adel_next  = ~mem_wr;
                        ades_next  = mem_wr;
                        rd_next    = '0;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    state_next = ST_DONE;
                    req_next   = 1'b0;
                    done_next  = 1'b1;
                    rd_next    = we_reg ? 32'h0 : al_rd;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ST_DONE;
                    req_next   = 1'b0;
                    done_next  = 1'b1;
                    err_next   = 1'b1;
                    rd_next    = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= DM_W;
            a_reg      <= 2'b00;
            done_reg   <= 1'b0;
            rd_reg     <= '0;
            adel_reg   <= 1'b0;
            ades_reg   <= 1'b0;
            err_reg    <= 1'b0;
            exc_pc_reg <= '0;
            req_reg    <= 1'b0;
            we_reg     <= 1'b0;
            baddr_reg  <= '0;
            be_reg     <= '0;
            wdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            op_reg     <= op_next;
            a_reg      <= a_next;
            done_reg   <= done_next;
            rd_reg     <= rd_next;
            adel_reg   <= adel_next;
            ades_reg   <= ades_next;
            err_reg    <= err_next;
            exc_pc_reg <= exc_pc_next;
            req_reg    <= req_next;
            we_reg     <= we_next;
            baddr_reg  <= baddr_next;
            be_reg     <= be_next;
            wdata_reg  <= wdata_next;
        end
    end

    assign done      = done_reg;
    assign rd        = rd_reg;
    assign exc_adel  = adel_reg;
    assign exc_ades  = ades_reg;
    assign bus_err   = err_reg;
    assign exc_pc    = exc_pc_reg;
    assign bus_req   = req_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = baddr_reg;
    assign bus_be    = be_reg;
    assign bus_wdata = wdata_reg;

endmodule

// File: doc/m_lsu.md
Name: m_lsu

Overview:
- Initiator-side load/store unit in the M stage of the five-stage MIPS pipeline; the requester end of the data-memory interface.
- Converts a pipeline access (address, store data, DMOp) into a word-aligned bus transaction with byte enables and lane-replicated write data.
- Handles a req/ack handshake with arbitrary wait states and stalls the pipeline until the access completes.
- Returns sign- or zero-extended load data; flags misaligned or out-of-range addresses as AdEL/AdES, and reports bus timeouts.

Parameters:
- ADDR_LIMIT, 32'h0000_2FFF, highest legal byte address (3072 words); above it → address exception.
- TIMEOUT_CYCLES, 255, REQ cycles without ack before the access is abandoned with bus_err.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc  input  32  PC of the M-stage instruction; latched for exception reporting.
- valid_in  input  1  M-stage instruction valid; held by the pipeline while stall=1.
- mem_rd  input  1  load.
- mem_wr  input  1  store; wins if mem_rd is also set.
- dm_op  input  3  DM_w/DM_h/DM_hu/DM_b/DM_bu.
- addr  input  32  byte address.
- wd  input  32  store data, right-justified.
- stall  output  1  freeze F..M stages.
- done  output  1  one-cycle completion pulse.
- rd  output  32  extended load data; valid when done=1.
- exc_adel  output  1  load address error; pulses with done.
- exc_ades  output  1  store address error; pulses with done.
- bus_err  output  1  timeout; pulses with done.
- exc_pc  output  32  PC of the faulting access.
- bus_req  output  1  request.
- bus_we  output  1  write.
- bus_addr  output  32  {addr[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated write data.
- bus_ack  input  1  responder accepts; rdata is valid in the same cycle.
- bus_rdata  input  32  read word.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, counter=0. All outputs 0, including bus_req, done, rd, exc_pc, bus_*.
- States: IDLE, REQ, DONE. All outputs are registered except stall.
- stall = (IDLE & valid_in & (mem_rd|mem_wr)) | REQ. stall is 0 in DONE, so the pipeline advances on the DONE→IDLE edge.
- IDLE with an access:
  - Legal iff aligned (w: addr[1:0]=0; h/hu: addr[0]=0; b/bu: always) and addr ≤ ADDR_LIMIT.
  - Illegal → DONE with exc_adel (load) or exc_ades (store) and exc_pc=pc. No bus activity.
  - Legal → REQ. Latch bus_addr, bus_we=mem_wr, bus_be, bus_wdata. bus_req=1 from the next cycle.
  - dm_op hu/bu on a store is treated as h/b.
- Byte enables:
  - w: 1111.
  - h: addr[1] ? 1100 : 0011.
  - b: 0001 << addr[1:0].
- Write data:
  - w: wd.
  - h: {2{wd[15:0]}}.
  - b: {4{wd[7:0]}}.
- REQ: bus_req and all bus_* stay stable until ack. The counter increments each REQ cycle.
  - On bus_ack: bus_req→0. For a load, rd ← extracted lane:
    - w: whole word.
    - h/hu: rdata[15+16*a1 -:16], sign/zero-extended.
    - b/bu: rdata[7+8*a[1:0] -:8], sign/zero-extended.
    - For a store, rd=0. Then → DONE.
  - When counter reaches TIMEOUT_CYCLES-1 without ack: bus_req→0, bus_err=1, rd=0, → DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: done=1 for exactly one cycle; exception/err flags are valid this cycle only. → IDLE, counter cleared. rd holds its value until the next completion.
- bus_ack outside REQ is ignored.
- valid_in dropped while in REQ (flush) does not abort. The transaction completes; the done pulse is still produced.
- Reset mid-transaction drops bus_req immediately, asynchronously. The responder must tolerate an abandoned request.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, REQ with immediate ack, DONE). There is no pipelining of requests.

Decomposition:
- Shared macro include gains the DM_* opcodes (already present), LSU state encodings, and the exception codes (AdEL=4, AdES=5).
- One natural sub-module: m_lsu_align, a combinational function block that produces be/wdata for stores and extract+extend for loads. It is reused by the DM model.

Test Plan:
- sw addr=0x0000_0010 wd=0x1234_5678, ack after 2 wait cycles → bus_addr=0x10, be=1111, wdata=0x12345678, stall high 4 cycles, done pulse.
- sh addr=0x12 wd=0xAAAA_BEEF, immediate ack → be=1100, wdata=0xBEEFBEEF, bus_addr=0x10.
- lb/lbu addr=0x23, bus_rdata=0x80FF_0000 → be=1000.
  - lb gives rd=0xFFFF_FF80.
  - lbu gives rd=0x0000_0080.
- lh addr=0x11 → no bus_req, done with exc_adel=1, exc_pc=pc.
- sw addr=0x3000 → exc_ades=1, no bus_req.
- lw with no ack → bus_err after 255 REQ cycles, rd=0. Reset asserted during REQ → bus_req=0 without waiting for a clock edge, state IDLE.
